// File: rtl/ikaopll_pkg.sv
// Shared constants and helper types for the IKAOPLL LFO-apply slice.
// Contents:
//   SLOT_COUNT              - operator slots per sample cycle (18)
//   FNUM_W/ATTEN_W/PHINC_W  - operand and result widths
//   slot_t                  - slot counter type
//   am_stage_t              - first-stage AM pipeline payload
//   sat_atten()             - clamp an attenuation sum to the 7-bit range
package ikaopll_pkg;

    localparam int unsigned SLOT_COUNT = 18;
    localparam int unsigned SLOT_W     = 5;
    localparam int unsigned FNUM_W     = 9;
    localparam int unsigned BLOCK_W    = 3;
    localparam int unsigned LFO_W      = 8;
    localparam int unsigned ATTEN_W    = 7;
    localparam int unsigned PHINC_W    = 16;
    // Doubled F-number: {fnum, 1'b0}.
    localparam int unsigned FREQ_W     = FNUM_W + 1;
    // Signed working width of the PM product and the modulated frequency.
    localparam int unsigned PM_W       = 12;
    // Only LFA[7:3] contributes to tremolo.
    localparam int unsigned AM_W       = 5;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic               vld;
        logic [ATTEN_W-1:0] atten;
    } am_stage_t;

    // The sum is at most 127 + 31, so the MSB alone flags overflow.
    function automatic logic [ATTEN_W-1:0] sat_atten(input logic [ATTEN_W:0] sum);
        sat_atten = sum[ATTEN_W] ? {ATTEN_W{1'b1}} : sum[ATTEN_W-1:0];
    endfunction

endpackage

// File: rtl/ikaopll_lfo_apply_pm.sv
// Vibrato (phase modulation) datapath: multiply, saturate, block shift.
// Two registered stages advance only when en_i is high.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - stage advance enable
//   fnum_i        - slot F-number (9 bits)
//   block_i       - slot octave block (3 bits)
//   pm_en_i       - slot vibrato enable
//   lfp_i         - LFO vibrato value, two's complement
//   phinc_o       - registered modulated phase increment (16 bits)
module ikaopll_lfo_apply_pm
    import ikaopll_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [FNUM_W-1:0]  fnum_i,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic               pm_en_i,
    input  logic [LFO_W-1:0]   lfp_i,
    output logic [PHINC_W-1:0] phinc_o
);

    logic signed [PM_W-1:0] pm_prod;
    logic signed [PM_W-1:0] pm_delta;
    logic signed [PM_W-1:0] freq_sum;
    logic [FREQ_W-1:0]      freq10_d, freq10_q;
    logic [BLOCK_W-1:0]     block_q;
    logic [PHINC_W:0]       freq_shl;
    logic [PHINC_W-1:0]     phinc_d, phinc_q;
    logic                   unused_shl_lsb;

    always_comb begin
        // Top three F-number bits (unsigned) times the signed LFO value.
        pm_prod = $signed({{(PM_W-3){1'b0}}, fnum_i[FNUM_W-1 -: 3]})
                * $signed({{(PM_W-LFO_W){lfp_i[LFO_W-1]}}, lfp_i});
        // Kept as a plain signed assignment so the shift stays arithmetic.
        pm_delta = pm_prod >>> 3;
        if (!pm_en_i) begin
            pm_delta = '0;
        end

        freq_sum = $signed({{(PM_W-FREQ_W){1'b0}}, fnum_i, 1'b0}) + pm_delta;

        // Range is -112..1133: sign bit means underflow, bit 10 means overflow.
        if (freq_sum[PM_W-1]) begin
            freq10_d = '0;
        end else if (|freq_sum[PM_W-2:FREQ_W]) begin
            freq10_d = {FREQ_W{1'b1}};
        end else begin
            freq10_d = freq_sum[FREQ_W-1:0];
        end

        freq_shl = {{(PHINC_W+1-FREQ_W){1'b0}}, freq10_q} << block_q;
        phinc_d  = freq_shl[PHINC_W:1];
    end

    assign unused_shl_lsb = freq_shl[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freq10_q <= '0;
            block_q  <= '0;
            phinc_q  <= '0;
        end else if (en_i) begin
            freq10_q <= freq10_d;
            block_q  <= block_i;
            phinc_q  <= phinc_d;
        end
    end

    assign phinc_o = phinc_q;

endmodule

// File: rtl/ikaopll_lfo_apply.sv
// Applies the LFO vibrato and tremolo values to the per-slot operands.
// Tracks the slot position, holds the LFO values for a whole 18-slot cycle,
// and delivers results through a 2-stage pipeline gated by the phi1 enable.
// Optional feature: define IKAOPLL_LFO_APPLY_SLOTNUM_EN to add o_DBG_SLOT.
// Ports:
//   i_EMUCLK       - master clock, rising edge
//   i_MRST_n       - asynchronous active-low reset
//   i_phi1_NCEN_n  - active-low clock enable
//   i_CYCLE_00     - marks the enabled cycle carrying slot 0
//   i_LFP / i_LFA  - LFO vibrato (signed) / tremolo (unsigned) values
//   i_FNUM, i_BLOCK, i_PM_EN, i_AM_EN, i_EG_ATTEN - current slot operands
//   o_PHINC        - modulated phase increment
//   o_ATTEN        - tremolo-applied attenuation
//   o_DBG_SLOT     - slot number aligned with outputs (optional)
//   o_VLD_SLOT0    - outputs belong to slot 0
module ikaopll_lfo_apply
    import ikaopll_pkg::*;
(
    input  logic               i_EMUCLK,
    input  logic               i_MRST_n,
    input  logic               i_phi1_NCEN_n,
    input  logic               i_CYCLE_00,
    input  logic [LFO_W-1:0]   i_LFP,
    input  logic [LFO_W-1:0]   i_LFA,
    input  logic [FNUM_W-1:0]  i_FNUM,
    input  logic [BLOCK_W-1:0] i_BLOCK,
    input  logic               i_PM_EN,
    input  logic               i_AM_EN,
    input  logic [ATTEN_W-1:0] i_EG_ATTEN,
    output logic [PHINC_W-1:0] o_PHINC,
    output logic [ATTEN_W-1:0] o_ATTEN,
`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
    output logic [SLOT_W-1:0]  o_DBG_SLOT,
`endif
    output logic               o_VLD_SLOT0
);

    localparam slot_t SlotLast = slot_t'(SLOT_COUNT - 1);

    logic               en;
    slot_t              slot_cnt_d, slot_cnt_q;
    logic [LFO_W-1:0]   lfp_q, lfp_eff;
    logic [AM_W-1:0]    lfa_q, lfa_eff, am_add;
    logic [ATTEN_W:0]   am_sum;
    am_stage_t          am_s1_d, am_s1_q;
    logic [ATTEN_W-1:0] atten_q;
    logic               vld_q;
    logic               unused_lfa_lsb;

    assign en = ~i_phi1_NCEN_n;

    // slot_cnt_q is the slot number of the current cycle unless i_CYCLE_00
    // overrides it; a slot-0 marker always resynchronises the count.
    always_comb begin
        if (i_CYCLE_00) begin
            slot_cnt_d = slot_t'(1);
        end else if (slot_cnt_q >= SlotLast) begin
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + slot_t'(1);
        end
    end

    // Write-through: the slot-0 cycle already uses the freshly presented LFO values.
    always_comb begin
        lfp_eff = i_CYCLE_00 ? i_LFP : lfp_q;
        lfa_eff = i_CYCLE_00 ? i_LFA[LFO_W-1 -: AM_W] : lfa_q;
        am_add  = i_AM_EN ? lfa_eff : '0;
        am_sum  = {1'b0, i_EG_ATTEN} + {{(ATTEN_W+1-AM_W){1'b0}}, am_add};
        am_s1_d.vld   = i_CYCLE_00;
        am_s1_d.atten = sat_atten(am_sum);
    end

    assign unused_lfa_lsb = ^i_LFA[LFO_W-AM_W-1:0];

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            slot_cnt_q <= '0;
            lfp_q      <= '0;
            lfa_q      <= '0;
            am_s1_q    <= '0;
            atten_q    <= '0;
            vld_q      <= 1'b0;
        end else if (en) begin
            slot_cnt_q <= slot_cnt_d;
            if (i_CYCLE_00) begin
                lfp_q <= i_LFP;
                lfa_q <= i_LFA[LFO_W-1 -: AM_W];
            end
            am_s1_q <= am_s1_d;
            atten_q <= am_s1_q.atten;
            vld_q   <= am_s1_q.vld;
        end
    end

    ikaopll_lfo_apply_pm u_pm (
        .clk_i   (i_EMUCLK),
        .rst_ni  (i_MRST_n),
        .en_i    (en),
        .fnum_i  (i_FNUM),
        .block_i (i_BLOCK),
        .pm_en_i (i_PM_EN),
        .lfp_i   (lfp_eff),
        .phinc_o (o_PHINC)
    );

    assign o_ATTEN     = atten_q;
    assign o_VLD_SLOT0 = vld_q;

`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
    slot_t slot_cur;
    slot_t dbg_s1_q, dbg_s2_q;

    assign slot_cur = i_CYCLE_00 ? '0 : slot_cnt_q;

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            dbg_s1_q <= '0;
            dbg_s2_q <= '0;
        end else if (en) begin
            dbg_s1_q <= slot_cur;
            dbg_s2_q <= dbg_s1_q;
        end
    end

    assign o_DBG_SLOT = dbg_s2_q;
`endif

endmodule

// File: tb/tb_ikaopll_lfo_apply.sv
// Directed bench for ikaopll_lfo_apply: reset, vibrato, tremolo, LFO hold
// across a cycle, and stall followed by a mid-cycle reset.
module tb_ikaopll_lfo_apply;

    logic       clk;
    logic       rst_n;
    logic       ncen;
    logic       cyc;
    logic [7:0] lfp;
    logic [7:0] lfa;
    logic [8:0] fnum;
    logic [2:0] block;
    logic       pm_en;
    logic       am_en;
    logic [6:0] eg;

    logic [15:0] phinc;
    logic [6:0]  atten;
    logic        vld;
`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
    logic [4:0]  dbg_slot;
`endif

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ikaopll_lfo_apply dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (rst_n),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_00    (cyc),
        .i_LFP         (lfp),
        .i_LFA         (lfa),
        .i_FNUM        (fnum),
        .i_BLOCK       (block),
        .i_PM_EN       (pm_en),
        .i_AM_EN       (am_en),
        .i_EG_ATTEN    (eg),
        .o_PHINC       (phinc),
        .o_ATTEN       (atten),
`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
        .o_DBG_SLOT    (dbg_slot),
`endif
        .o_VLD_SLOT0   (vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic [7:0] p, input logic [7:0] a,
                         input logic [8:0] f, input logic [2:0] b, input logic pe,
                         input logic ae, input logic [6:0] e);
        cyc   = c;
        lfp   = p;
        lfa   = a;
        fnum  = f;
        block = b;
        pm_en = pe;
        am_en = ae;
        eg    = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ncen  = 1'b0;
        drive(1'b1, 8'd8, 8'hF8, 9'h1C0, 3'd4, 1'b1, 1'b1, 7'd50);
        tick();
        tick();
        n_cmp++;
        if (phinc !== 16'd0) begin
            n_err++;
            $display("FAIL reset_phinc: got %0d want 0", phinc);
        end
        n_cmp++;
        if (atten !== 7'd0) begin
            n_err++;
            $display("FAIL reset_atten: got %0d want 0", atten);
        end
        n_cmp++;
        if (vld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vld: got %0b want 0", vld);
        end
`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
        n_cmp++;
        if (dbg_slot !== 5'd0) begin
            n_err++;
            $display("FAIL reset_dbg: got %0d want 0", dbg_slot);
        end
`endif
        #2 rst_n = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0, 7'd0);
    endtask

    task automatic test_pm();
        logic [7:0]  v_lfp   [4];
        logic [8:0]  v_fnum  [4];
        logic [2:0]  v_block [4];
        logic        v_pe    [4];
        logic [15:0] v_exp   [4];
        v_lfp   = '{8'd8, 8'hF8, 8'hF8, 8'd127};
        v_fnum  = '{9'h1C0, 9'h1C0, 9'h1C0, 9'h1FF};
        v_block = '{3'd4, 3'd0, 3'd0, 3'd7};
        v_pe    = '{1'b1, 1'b1, 1'b0, 1'b1};
        v_exp   = '{16'd7224, 16'd444, 16'd448, 16'd65472};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v_lfp[i], 8'd0, v_fnum[i], v_block[i], v_pe[i], 1'b0, 7'd0);
            tick();
            drive(1'b0, 8'h55, 8'd0, 9'd0, 3'd0, 1'b1, 1'b0, 7'd0);
            tick();
            n_cmp++;
            if (phinc !== v_exp[i]) begin
                n_err++;
                $display("FAIL pm_vec%0d: got %0d want %0d", i, phinc, v_exp[i]);
            end
            n_cmp++;
            if (vld !== 1'b1) begin
                n_err++;
                $display("FAIL pm_vld%0d: got %0b want 1", i, vld);
            end
            tick();
            n_cmp++;
            if (phinc !== 16'd0 || vld !== 1'b0) begin
                n_err++;
                $display("FAIL pm_next%0d: got phinc %0d vld %0b want 0/0", i, phinc, vld);
            end
        end
    endtask

    task automatic test_am();
        logic [6:0] v_eg   [5];
        logic [7:0] v_lfa  [5];
        logic       v_am   [5];
        logic [6:0] v_exp  [5];
        logic [6:0] v_exp2 [5];
        v_eg   = '{7'd120, 7'd10, 7'd10, 7'd124, 7'd123};
        v_lfa  = '{8'hF8, 8'h28, 8'h28, 8'h20, 8'h20};
        v_am   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        v_exp  = '{7'd127, 7'd15, 7'd10, 7'd127, 7'd127};
        // Follow-up slot: EG=3 with AM on, using the held LFA.
        v_exp2 = '{7'd34, 7'd8, 7'd8, 7'd7, 7'd7};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd0, v_lfa[i], 9'd0, 3'd0, 1'b0, v_am[i], v_eg[i]);
            tick();
            drive(1'b0, 8'd0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b1, 7'd3);
            tick();
            n_cmp++;
            if (atten !== v_exp[i]) begin
                n_err++;
                $display("FAIL am_vec%0d: got %0d want %0d", i, atten, v_exp[i]);
            end
            tick();
            n_cmp++;
            if (atten !== v_exp2[i]) begin
                n_err++;
                $display("FAIL am_hold%0d: got %0d want %0d", i, atten, v_exp2[i]);
            end
        end
    endtask

    task automatic test_lfo_hold();
        logic [15:0] exp_ph;
        int          sp;
        for (int s = 0; s <= 20; s++) begin
            drive((s == 0 || s == 18), (s < 9) ? 8'd8 : 8'hF8, 8'd0, 9'h1C0, 3'd0, 1'b1,
                  1'b0, 7'(s));
            tick();
            if (s >= 1) begin
                sp     = s - 1;
                exp_ph = (sp < 18) ? 16'd451 : 16'd444;
                n_cmp++;
                if (phinc !== exp_ph) begin
                    n_err++;
                    $display("FAIL hold_phinc slot%0d: got %0d want %0d", sp, phinc, exp_ph);
                end
                n_cmp++;
                if (atten !== 7'(sp)) begin
                    n_err++;
                    $display("FAIL hold_atten slot%0d: got %0d want %0d", sp, atten, sp);
                end
                n_cmp++;
                if (vld !== (sp == 0 || sp == 18)) begin
                    n_err++;
                    $display("FAIL hold_vld slot%0d: got %0b want %0b", sp, vld,
                             (sp == 0 || sp == 18));
                end
`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
                n_cmp++;
                if (dbg_slot !== 5'(sp % 18)) begin
                    n_err++;
                    $display("FAIL hold_dbg slot%0d: got %0d want %0d", sp, dbg_slot, sp % 18);
                end
`endif
            end
        end
    endtask

    task automatic test_stall_reset();
        for (int s = 0; s <= 6; s++) begin
            drive((s == 0), 8'd0, 8'd0, 9'(100 + s), 3'd0, 1'b0, 1'b0, 7'(20 + s));
            tick();
        end
        n_cmp++;
        if (atten !== 7'd25 || phinc !== 16'd105) begin
            n_err++;
            $display("FAIL pre_stall: got atten %0d phinc %0d want 25/105", atten, phinc);
        end
        ncen = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'd127, 8'hF8, 9'h1FF, 3'd7, 1'b1, 1'b1, 7'd99);
            tick();
            n_cmp++;
            if (atten !== 7'd25 || phinc !== 16'd105 || vld !== 1'b0) begin
                n_err++;
                $display("FAIL stall%0d: got atten %0d phinc %0d vld %0b want 25/105/0",
                         k, atten, phinc, vld);
            end
        end
        ncen = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 9'd106, 3'd0, 1'b0, 1'b0, 7'd26);
        tick();
        n_cmp++;
        if (atten !== 7'd26 || phinc !== 16'd106) begin
            n_err++;
            $display("FAIL post_stall: got atten %0d phinc %0d want 26/106", atten, phinc);
        end
        // Slot 7: reset lands between edges.
        drive(1'b0, 8'd0, 8'd0, 9'd107, 3'd0, 1'b0, 1'b0, 7'd27);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (atten !== 7'd0 || phinc !== 16'd0 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got atten %0d phinc %0d vld %0b want 0/0/0",
                     atten, phinc, vld);
        end
        tick();
        n_cmp++;
        if (atten !== 7'd0 || phinc !== 16'd0 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL in_reset: got atten %0d phinc %0d vld %0b want 0/0/0",
                     atten, phinc, vld);
        end
        #2 rst_n = 1'b1;
        // LFA not latched (no slot-0 marker): held value must be the reset 0.
        drive(1'b0, 8'd0, 8'hF8, 9'd0, 3'd0, 1'b0, 1'b1, 7'd10);
        tick();
        drive(1'b0, 8'd0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0, 7'd11);
        tick();
        n_cmp++;
        if (atten !== 7'd10 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: got atten %0d vld %0b want 10/0", atten, vld);
        end
`ifdef IKAOPLL_LFO_APPLY_SLOTNUM_EN
        n_cmp++;
        if (dbg_slot !== 5'd0) begin
            n_err++;
            $display("FAIL after_reset_dbg: got %0d want 0", dbg_slot);
        end
`endif
        drive(1'b1, 8'd0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0, 7'd60);
        tick();
        drive(1'b0, 8'd0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0, 7'd61);
        tick();
        n_cmp++;
        if (vld !== 1'b1 || atten !== 7'd60) begin
            n_err++;
            $display("FAIL resync_vld: got vld %0b atten %0d want 1/60", vld, atten);
        end
        tick();
        n_cmp++;
        if (vld !== 1'b0 || atten !== 7'd61) begin
            n_err++;
            $display("FAIL resync_next: got vld %0b atten %0d want 0/61", vld, atten);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ncen  = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0, 7'd0);
        test_reset();
        test_pm();
        test_am();
        test_lfo_hold();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ikaopll_lfo_apply.md
IKAOPLL_LFO_APPLY -- requirements
Module: IKAOPLL_lfo_apply

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: i_EMUCLK (input, 1, emulator master clock, all flops rising-edge) first, i_MRST_n (input, 1, asynchronous active-low core reset) second.
REQ-002 SHALL have i_phi1_NCEN_n (input, 1): active-low clock enable; all state advances only on i_EMUCLK edges where it is 0.
REQ-003 SHALL have i_CYCLE_00 (input, 1): slot-0 sync, high during the enabled cycle that presents slot 0.
REQ-004 SHALL have i_LFP (input, 8): vibrato value from the LFO, two's complement.
REQ-005 SHALL have i_LFA (input, 8): tremolo value from the LFO, unsigned.
REQ-006 SHALL have i_FNUM (input, 9), i_BLOCK (input, 3), i_PM_EN (input, 1), i_AM_EN (input, 1) and i_EG_ATTEN (input, 7): per-slot operands for the current slot.
REQ-007 SHALL have o_PHINC (output, 16): modulated phase increment.
REQ-008 SHALL have o_ATTEN (output, 7): tremolo-applied attenuation.
REQ-009 SHALL have o_VLD_SLOT0 (output, 1): high when outputs belong to slot 0.

Function
REQ-010 SHALL keep a 5-bit slot counter 0..17 that increments per enabled cycle, wraps 17->0, and loads 1 on an enabled cycle with i_CYCLE_00=1, even when i_CYCLE_00 arrives mid-count.
REQ-011 SHALL latch i_LFP/i_LFA into hold registers only on enabled cycles with i_CYCLE_00=1, so all 18 slots of one cycle use the same values.
REQ-012 SHALL compute pm_delta = (i_FNUM[8:6] x held_LFP) arithmetic-shifted right 3, signed 12-bit, and force it to 0 when i_PM_EN=0.
REQ-013 SHALL compute freq10 = {i_FNUM,1'b0} + pm_delta and saturate it to 0..1023.
REQ-014 SHALL compute o_PHINC = (freq10 << i_BLOCK) >> 1, zero-extended to 16 bits.
REQ-015 SHALL compute o_ATTEN = i_EG_ATTEN + (i_AM_EN ? held_LFA[7:3] : 0), saturated to 127.
REQ-016 SHALL register both datapaths in a 2-stage pipeline: operands sampled on enabled cycle N appear on the outputs after enabled cycle N+2.
REQ-017 SHALL hold all outputs and pipeline stages unchanged on cycles with i_phi1_NCEN_n=1.
REQ-018 SHALL raise o_VLD_SLOT0 exactly 2 enabled cycles after the i_CYCLE_00 cycle.
REQ-019 SHALL compute the slot that carries i_CYCLE_00 with the newly latched LFO values (write-through).

Reset
REQ-020 SHALL, while i_MRST_n=0, asynchronously clear the slot counter, hold registers, pipeline stages, o_PHINC, o_ATTEN and o_VLD_SLOT0 to 0.
REQ-021 SHALL, when reset is asserted mid-cycle, discard all in-flight slots; after release the first enabled cycle resumes counting from 0 until i_CYCLE_00 resynchronises it.

Configuration
REQ-022 SHALL, with IKAOPLL_LFO_APPLY_SLOTNUM_EN defined, add output o_DBG_SLOT (5 bits): the slot number aligned with o_PHINC/o_ATTEN, reset 0.
REQ-023 SHALL, without IKAOPLL_LFO_APPLY_SLOTNUM_EN, omit that port and its pipeline flops, with all other behaviour identical.

Structure
REQ-024 SHALL take SLOT_COUNT=18 and the widths FNUM_W=9, ATTEN_W=7 and PHINC_W=16 from shared package IKAOPLL_pkg.
REQ-025 SHALL place the PM multiply/saturate/shift datapath in sub-module IKAOPLL_lfo_apply_pm; AM and control logic stay in the top module.

Verification
REQ-026 SHALL cover: LFP=+8, FNUM=0x1C0, BLOCK=4, PM_EN=1 -> o_PHINC=7224 two enabled cycles later.
REQ-027 SHALL cover: LFP=-8, FNUM=0x1C0, BLOCK=0, PM_EN=1 -> o_PHINC=444; same operands with PM_EN=0 -> 448.
REQ-028 SHALL cover: FNUM=0x1FF, LFP=+127, BLOCK=7 -> freq10 saturates at 1023 and o_PHINC=65472.
REQ-029 SHALL cover: EG=120, LFA=0xF8, AM_EN=1 -> o_ATTEN=127; EG=10, LFA=0x28 -> 15; EG=10, AM_EN=0 -> 10.
REQ-030 SHALL cover: i_LFP changed mid-cycle (slot 9) -> slots 9..17 still use the slot-0 value; the new value applies from the next i_CYCLE_00.
REQ-031 SHALL cover: i_phi1_NCEN_n=1 for 5 cycles, then reset pulsed at slot 7 -> outputs frozen during the stall, all 0 during reset, and o_VLD_SLOT0 reasserts 2 enabled cycles after the next i_CYCLE_00.
